anita4_trigger_scaler_bank: RTL and testbench
=============================================

// Module: anita4_trigger_scaler_bank
// PURPOSE
//  Downstream consumer of the dual-phi L1/L2 trigger stage's scaler flags: 6 L1 + 2 L2 single-cycle
//  pulses, already synchronised into the mclk domain. Counts pulses per channel over a programmable
//  gate period. At each period end, snapshots the live counts into holding registers for register
//  readout. Runs entirely in the mclk domain, which is the only clock.
// PARAMETERS
//  NUM_CH    8   channels; index 0-5 = L1 flags {T0,M0,B0,T1,M1,B1} (MSB first), 6-7 = L2 phi0/phi1
//  CNT_W     16  counter/hold width; counters saturate at all-ones
//  PERIOD_W  24  width of gate-period register (period in clk cycles)
//  SEQ_W     8   snapshot sequence-number width
// PORTS
//  clk_i         in   1               mclk-domain clock
//  rst_n_i       in   1               async assert, active-low reset (sync deassert upstream)
//  flag_i        in   NUM_CH          1-cycle scaler pulses from flag_sync outputs
//  period_i      in   PERIOD_W        gate period in cycles; 0 = gating disabled
//  sel_i         in   $clog2(NUM_CH)  readout channel select
//  data_o        out  CNT_W           held count of channel sel_i
//  ovf_o         out  NUM_CH          per-channel saturation flag for the held interval
//  snap_o        out  1               1-cycle strobe: new hold/ovf/seq values valid this cycle
//  snap_seq_o    out  SEQ_W           snapshot counter, wraps modulo 2^SEQ_W
// BEHAVIOUR
//  - Reset (rst_n_i=0, async): live, hold, ovf, tick counter, seq, data_o, snap_o all clear to 0.
//  - Live count: each cycle, live[k] += flag_i[k]. Saturates at 2^CNT_W-1; live_ovf[k] then sets.
//  - Tick counter: 0..period_i-1. Snapshot cycle = (period_i!=0) && (tick >= period_i-1).
//    The >= comparison means a lowered period_i fires on the next cycle; tick then returns to 0.
//  - Snapshot edge: hold[k] <= live[k]+flag_i[k] (saturating); ovf_o[k] <= live_ovf[k] | new sat.
//    Also: live[k] <= 0; live_ovf <= 0; snap_seq_o += 1; snap_o=1 for exactly the following cycle.
//    A flag coincident with the snapshot cycle counts in the CLOSING interval, not the new one.
//  - period_i==0: no snapshots. tick is held at 0. Live counters keep counting and saturating.
//  - period_i is sampled every cycle; no holding register. Software changes it only while gating is off.
//  - Readout: data_o <= hold[sel_i], registered, 1-cycle latency.
//    sel_i >= NUM_CH gives data_o=0. A snapshot edge updates data_o on the following cycle.
//  - No backpressure: snap_o is informational; holds are overwritten at every period end.
// CONFIGURATION
//  SCALER_PPS_GATE_EN defined:
//    - Adds input pps_i (async). Synchronised by 2 FFs, then rising-edge detected.
//    - The detected edge is the snapshot cycle; period_i and tick counter are removed.
//    - Latency: pps_i rise to snap_o = 4 clk cycles.
//  SCALER_PPS_GATE_EN undefined: internal period gating as above; no pps_i port.
// STRUCTURE
//  Package anita4_scaler_pkg holds:
//    - NUM_CH, CNT_W, SEQ_W defaults
//    - channel-index localparams CH_L1_TOP0..CH_L1_BOT1, CH_L2_PHI0, CH_L2_PHI1
//  Sub-module anita4_sat_counter (one channel):
//    - inputs: inc, clr_load (snapshot)
//    - outputs: cnt, sat, next_cnt for the hold capture
//    - instantiated NUM_CH times via generate
//  Top holds: tick/snapshot logic, hold array, readout mux, seq counter.
// TESTING
//  1 rst_n_i low mid-run, all flags high -> all outputs 0 within same cycle; snap_seq_o=0 after release
//  2 period_i=10, flag_i[0]=1 every cycle -> snap_o every 10 cycles, sel_i=0 data_o=10, seq 1,2,3..
//  3 period_i=100000, flag_i[3] held high 70000 cycles -> data_o(sel 3)=16'hFFFF, ovf_o[3]=1, others 0
//  4 period_i=10, one pulse on flag_i[6] in snapshot cycle -> held=1 this interval, next interval 0
//  5 period_i=0 for 1000 cycles -> no snap_o; set period_i=5 -> snap_o within 5 cycles, count correct
//  6 (SCALER_PPS_GATE_EN) pps_i rise, 3 flag_i[7] pulses before -> snap_o 4 cycles later, data_o=3

Source files
------------

// File: rtl/anita4_scaler_pkg.sv
// Shared defaults and channel map for the ANITA-4 trigger scaler bank.
package anita4_scaler_pkg;

  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned SEQ_W    = 8;
  localparam int unsigned PERIOD_W = 24;

  // flag_i[5:0] = {T0,M0,B0,T1,M1,B1}; L2 phi flags sit above the L1 group
  localparam int unsigned CH_L1_TOP0 = 5;
  localparam int unsigned CH_L1_MID0 = 4;
  localparam int unsigned CH_L1_BOT0 = 3;
  localparam int unsigned CH_L1_TOP1 = 2;
  localparam int unsigned CH_L1_MID1 = 1;
  localparam int unsigned CH_L1_BOT1 = 0;
  localparam int unsigned CH_L2_PHI0 = 6;
  localparam int unsigned CH_L2_PHI1 = 7;

endpackage

// File: rtl/anita4_sat_counter.sv
// Single-channel saturating pulse counter with snapshot clear.
module anita4_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             clr_load_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o,
  output logic [CNT_W-1:0] next_cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  assign next_cnt_o = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(inc_i);
  assign cnt_o      = cnt_q;
  assign sat_o      = sat_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (clr_load_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= next_cnt_o;
      if (&next_cnt_o) sat_q <= 1'b1;
    end
  end

endmodule

// File: rtl/anita4_trigger_scaler_bank.sv
// Per-channel trigger scaler bank with gated snapshot into holding registers.
// SCALER_PPS_GATE_EN: gate on synchronised pps_i rising edge instead of period_i.
module anita4_trigger_scaler_bank #(
  parameter int unsigned NUM_CH = anita4_scaler_pkg::NUM_CH,
  parameter int unsigned CNT_W  = anita4_scaler_pkg::CNT_W,
  parameter int unsigned SEQ_W  = anita4_scaler_pkg::SEQ_W
`ifndef SCALER_PPS_GATE_EN
  , parameter int unsigned PERIOD_W = anita4_scaler_pkg::PERIOD_W
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_CH-1:0]         flag_i,
`ifdef SCALER_PPS_GATE_EN
  input  logic                      pps_i,
`else
  input  logic [PERIOD_W-1:0]       period_i,
`endif
  input  logic [$clog2(NUM_CH)-1:0] sel_i,
  output logic [CNT_W-1:0]          data_o,
  output logic [NUM_CH-1:0]         ovf_o,
  output logic                      snap_o,
  output logic [SEQ_W-1:0]          snap_seq_o
);

  import anita4_scaler_pkg::*;

  logic [NUM_CH-1:0][CNT_W-1:0] live_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0] next_cnt;
  logic [NUM_CH-1:0]            live_sat;
  logic                         snap_cycle;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    anita4_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .inc_i      (flag_i[k]),
      .clr_load_i (snap_cycle),
      .cnt_o      (live_cnt[k]),
      .sat_o      (live_sat[k]),
      .next_cnt_o (next_cnt[k])
    );
  end

`ifdef SCALER_PPS_GATE_EN
  logic pps_s1_q, pps_s2_q, pps_s3_q, pps_rise_q;

  // Edge detect is registered so the snapshot lands 4 cycles after the pps rise
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pps_s1_q   <= 1'b0;
      pps_s2_q   <= 1'b0;
      pps_s3_q   <= 1'b0;
      pps_rise_q <= 1'b0;
    end else begin
      pps_s1_q   <= pps_i;
      pps_s2_q   <= pps_s1_q;
      pps_s3_q   <= pps_s2_q;
      pps_rise_q <= pps_s2_q & ~pps_s3_q;
    end
  end

  assign snap_cycle = pps_rise_q;
`else
  logic [PERIOD_W-1:0] tick_q, tick_d;

  // >= lets a lowered period close the interval immediately
  always_comb begin
    snap_cycle = (period_i != '0) && (tick_q >= period_i - PERIOD_W'(1));
    tick_d     = tick_q + PERIOD_W'(1);
    if ((period_i == '0) || snap_cycle) tick_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tick_q <= '0;
    else          tick_q <= tick_d;
  end
`endif

  logic [NUM_CH-1:0][CNT_W-1:0] hold_q;
  logic [NUM_CH-1:0]            ovf_q, ovf_d;
  logic [SEQ_W-1:0]             seq_q;
  logic                         snap_q;
  logic [CNT_W-1:0]             data_q, data_d;

  // Saturation reached on the closing cycle itself still marks the interval
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      ovf_d[k] = live_sat[k] | ((&next_cnt[k]) & ~(&live_cnt[k]));
    end
  end

  always_comb begin
    data_d = '0;
    if (32'(sel_i) < NUM_CH) data_d = hold_q[sel_i];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_q <= '0;
      ovf_q  <= '0;
      seq_q  <= '0;
      snap_q <= 1'b0;
      data_q <= '0;
    end else begin
      snap_q <= snap_cycle;
      data_q <= data_d;
      if (snap_cycle) begin
        hold_q <= next_cnt;
        ovf_q  <= ovf_d;
        seq_q  <= seq_q + SEQ_W'(1);
      end
    end
  end

  assign data_o     = data_q;
  assign ovf_o      = ovf_q;
  assign snap_o     = snap_q;
  assign snap_seq_o = seq_q;

endmodule

// File: tb/tb_anita4_trigger_scaler_bank.sv
// Randomised bench for anita4_trigger_scaler_bank against a per-cycle behavioural model.
module tb_anita4_trigger_scaler_bank;
  import anita4_scaler_pkg::*;

  localparam int NCH  = 8;
  localparam int MAXC = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  flag;
  logic [23:0] period;
  logic [2:0]  sel;
  logic        pps;
  logic [15:0] data;
  logic [7:0]  ovf;
  logic        snap;
  logic [7:0]  seq;

  always #5 clk = ~clk;

  anita4_trigger_scaler_bank dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .flag_i     (flag),
`ifdef SCALER_PPS_GATE_EN
    .pps_i      (pps),
`else
    .period_i   (period),
`endif
    .sel_i      (sel),
    .data_o     (data),
    .ovf_o      (ovf),
    .snap_o     (snap),
    .snap_seq_o (seq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference state
  int       m_live[NCH];
  bit       m_lovf[NCH];
  int       m_hold[NCH];
  bit [7:0] m_ovf;
  int       m_seq;
  bit       m_snap;
  int       m_data;
  int       m_tick;
  bit       m_pps[4];

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_live[k] = 0; m_lovf[k] = 0; m_hold[k] = 0;
    end
    for (int i = 0; i < 4; i++) m_pps[i] = 0;
    m_ovf = '0; m_seq = 0; m_snap = 0; m_data = 0; m_tick = 0;
  endfunction

  function automatic void model_edge();
    bit fire;
    int sum;
    bit sat;
    m_data = (int'(sel) < NCH) ? m_hold[sel] : 0;
`ifdef SCALER_PPS_GATE_EN
    fire = m_pps[2] && !m_pps[3];
    for (int i = 3; i > 0; i--) m_pps[i] = m_pps[i-1];
    m_pps[0] = pps;
`else
    fire = (period != 0) && (m_tick >= int'(period) - 1);
    m_tick = (period == 0 || fire) ? 0 : m_tick + 1;
`endif
    for (int k = 0; k < NCH; k++) begin
      sum = m_live[k] + int'(flag[k]);
      sat = (sum >= MAXC);
      if (sum > MAXC) sum = MAXC;
      if (fire) begin
        m_hold[k] = sum;
        m_ovf[k]  = m_lovf[k] | sat;
        m_live[k] = 0;
        m_lovf[k] = 0;
      end else begin
        m_live[k] = sum;
        m_lovf[k] = m_lovf[k] | sat;
      end
    end
    if (fire) m_seq = (m_seq + 1) % 256;
    m_snap = fire;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_data"}, 32'(data), 32'(m_data));
    chk({tag, "_ovf"},  32'(ovf),  32'(m_ovf));
    chk({tag, "_snap"}, 32'(snap), 32'(m_snap));
    chk({tag, "_seq"},  32'(seq),  32'(m_seq));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  int nsnap;
  int n;

  initial begin
    rst_n = 1'b1; flag = '0; period = '0; sel = '0; pps = 1'b0;
    #3;
    do_reset();

`ifndef SCALER_PPS_GATE_EN
    // Random warm-up, then reset mid-run with every flag high
    period = 24'd7;
    for (int i = 0; i < 60; i++) begin
      flag = 8'($urandom); sel = 3'($urandom);
      step("warm");
    end
    flag = '1;
    do_reset();
    chk("t1_seq", 32'(seq), 32'd0);
    step("t1");

    // Continuous flag on channel 0, period 10
    do_reset();
    period = 24'd10; flag = 8'h01; sel = 3'd0; nsnap = 0;
    for (int i = 0; i < 35; i++) begin
      step("t2");
      if (snap) nsnap++;
    end
    chk("t2_nsnap", 32'(nsnap), 32'd3);
    chk("t2_data", 32'(data), 32'd10);
    chk("t2_seq", 32'(seq), 32'd3);

    // Saturation: 70000 pulses, then lower period to close the interval
    do_reset();
    period = 24'd100000; flag = '0; flag[CH_L1_BOT0] = 1'b1; sel = 3'(CH_L1_BOT0);
    for (int i = 0; i < 70000; i++) step("t3");
    period = 24'd1;
    step("t3c");
    chk("t3_snap", 32'(snap), 32'd1);
    period = '0; flag = '0;
    step("t3r");
    chk("t3_data", 32'(data), 32'hFFFF);
    chk("t3_ovf", 32'(ovf), 32'h08);

    // Pulse coincident with the snapshot cycle counts in the closing interval
    do_reset();
    period = 24'd10; flag = '0; sel = 3'(CH_L2_PHI0);
    for (int i = 0; i < 9; i++) step("t4a");
    flag[CH_L2_PHI0] = 1'b1;
    step("t4b");
    chk("t4_snap", 32'(snap), 32'd1);
    flag = '0;
    step("t4c");
    chk("t4_hold", 32'(data), 32'd1);
    for (int i = 0; i < 10; i++) step("t4d");
    chk("t4_next", 32'(data), 32'd0);

    // Gating off for 1000 cycles, then enable with period 5
    do_reset();
    period = '0; nsnap = 0;
    for (int i = 0; i < 1000; i++) begin
      flag = 8'($urandom); sel = 3'($urandom);
      step("t5a");
      if (snap) nsnap++;
    end
    chk("t5_nosnap", 32'(nsnap), 32'd0);
    period = 24'd5; flag = '0; n = 0;
    while (!snap && n < 10) begin
      step("t5b");
      n++;
    end
    chk("t5_lat", 32'(n), 32'd5);
    step("t5c");

    // Random periods, flags and selects; gating dropped to 0 between changes
    for (int r = 0; r < 20; r++) begin
      period = '0;
      step("rnd0");
      period = 24'($urandom_range(1, 40));
      for (int i = 0; i < 100; i++) begin
        flag = 8'($urandom); sel = 3'($urandom);
        step("rnd");
      end
    end
`else
    flag = '1;
    for (int i = 0; i < 20; i++) step("warm");
    do_reset();
    chk("t1_seq", 32'(seq), 32'd0);
    flag = '0;

    // Three pulses on L2 phi1, then a pps rising edge
    sel = 3'(CH_L2_PHI1);
    for (int i = 0; i < 3; i++) begin
      flag[CH_L2_PHI1] = 1'b1;
      step("t6a");
      flag = '0;
      step("t6b");
    end
    pps = 1'b1; n = 0;
    while (!snap && n < 10) begin
      step("t6c");
      n++;
    end
    chk("t6_lat", 32'(n), 32'd4);
    step("t6d");
    chk("t6_data", 32'(data), 32'd3);

    for (int i = 0; i < 2000; i++) begin
      flag = 8'($urandom); sel = 3'($urandom);
      if ($urandom_range(0, 15) == 0) pps = ~pps;
      step("rnd");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
